// File: rtl/sb_pkg.sv
// Shared types and helpers for the switchboard stream sink.
// Provides:
//   SB_DEST_W / SB_CNT_W / SB_LFSR_W  field and counter widths
//   sb_ready_mode_e                   ready throttling modes
//   sb_decode_mode()                  maps a raw 2-bit mode to a legal mode (3 -> always)
//   sb_lfsr_step()                    one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package sb_pkg;

    localparam int unsigned SB_DEST_W = 32;
    localparam int unsigned SB_CNT_W  = 32;
    localparam int unsigned SB_LFSR_W = 16;

    typedef enum logic [1:0] {
        SB_RDY_ALWAYS = 2'd0,
        SB_RDY_RANDOM = 2'd1,
        SB_RDY_ALT    = 2'd2
    } sb_ready_mode_e;

    // Unused encoding 3 falls back to always-ready.
    function automatic sb_ready_mode_e sb_decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return SB_RDY_RANDOM;
            2'd2:    return SB_RDY_ALT;
            default: return SB_RDY_ALWAYS;
        endcase
    endfunction

    // Feedback from bits 0,2,3,5 enters at the top; the register shifts right.
    function automatic logic [SB_LFSR_W-1:0] sb_lfsr_step(input logic [SB_LFSR_W-1:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[SB_LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/sb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, nreset   clock, async active-low reset (pointers only; storage is not reset)
//   push          write push_data (ignored when full)
//   push_data     entry to store
//   pop           advance head (ignored when empty)
//   full, empty   occupancy flags
//   level         number of stored entries, 0..DEPTH
//   head          oldest entry, valid while !empty
module sb_sync_fifo #(
    parameter  int unsigned DW_FIFO = 449,
    parameter  int unsigned DEPTH   = 4,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               push,
    input  logic [DW_FIFO-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [LVL_W-1:0]   level,
    output logic [DW_FIFO-1:0] head
);

    localparam int unsigned PW = AW + 1;

    logic [DW_FIFO-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_q, wr_d;
    logic [PW-1:0]      rd_q, rd_d;
    logic               do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign level   = LVL_W'(wr_q - rd_q);
    assign head    = mem_q[rd_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer next-state.
    always_comb begin
        wr_d = wr_q + PW'(do_push);
        rd_d = rd_q + PW'(do_pop);
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sb_stream_sink.sv
// Consumer end of a switchboard beat stream.
// Buffers accepted beats in a FWFT FIFO, throttles ready by mode, counts beats/packets.
// Ports:
//   clk, nreset                       clock, async active-low reset
//   data, dest, last, valid / ready   incoming beat stream (ready is registered)
//   ready_mode_sel, ready_mode        0: READY_MODE_DEFAULT, 1: ready_mode (3 -> always)
//   out_data, out_dest, out_last      head beat, meaningful while out_valid
//   out_valid / out_ready             local consumer handshake
//   level                             FIFO occupancy
//   beat_count, pkt_count             accepted beats / accepted beats with last (wrapping)
module sb_stream_sink
    import sb_pkg::*;
#(
    parameter  int unsigned          DW                 = 416,
    parameter  int unsigned          DEPTH              = 4,
    parameter  int unsigned          READY_MODE_DEFAULT = 0,
    parameter  logic [SB_LFSR_W-1:0] LFSR_SEED          = 16'hACE1,
    localparam int unsigned          LVL_W              = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [DW-1:0]        data,
    input  logic [SB_DEST_W-1:0] dest,
    input  logic                 last,
    input  logic                 valid,
    output logic                 ready,
    input  logic                 ready_mode_sel,
    input  logic [1:0]           ready_mode,
    output logic [DW-1:0]        out_data,
    output logic [SB_DEST_W-1:0] out_dest,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LVL_W-1:0]     level,
    output logic [SB_CNT_W-1:0]  beat_count,
    output logic [SB_CNT_W-1:0]  pkt_count
);

    localparam int unsigned FW = DW + SB_DEST_W + 1;

    logic                 push, pop, full, empty;
    logic [FW-1:0]        head;
    logic [LVL_W-1:0]     lvl_nxt;
    sb_ready_mode_e       mode_eff;
    logic                 gate;
    logic                 ready_q, ready_d;
    logic                 toggle_q, toggle_d;
    logic [SB_LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [SB_CNT_W-1:0]  beat_q, beat_d;
    logic [SB_CNT_W-1:0]  pkt_q, pkt_d;

    assign push = valid && ready_q && !full;
    assign pop  = out_ready && !empty;

    sb_sync_fifo #(
        .DW_FIFO (FW),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nreset    (nreset),
        .push      (push),
        .push_data ({last, dest, data}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .head      (head)
    );

    assign {out_last, out_dest, out_data} = head;
    assign out_valid  = !empty;
    assign ready      = ready_q;
    assign beat_count = beat_q;
    assign pkt_count  = pkt_q;

    // Next ready is judged against next-cycle occupancy, so a pop while full cannot
    // pass a beat straight through; ready recovers one cycle later.
    always_comb begin
        mode_eff = ready_mode_sel ? sb_decode_mode(ready_mode)
                                  : sb_decode_mode(2'(READY_MODE_DEFAULT));
        gate     = 1'b1;
        case (mode_eff)
            SB_RDY_RANDOM: gate = lfsr_q[0];
            SB_RDY_ALT:    gate = toggle_q;
            default:       gate = 1'b1;
        endcase
        lvl_nxt  = level + LVL_W'(push) - LVL_W'(pop);
        ready_d  = (lvl_nxt != LVL_W'(DEPTH)) && gate;
        lfsr_d   = sb_lfsr_step(lfsr_q);
        toggle_d = !toggle_q;
        beat_d   = beat_q + SB_CNT_W'(push);
        pkt_d    = pkt_q + SB_CNT_W'(push && last);
    end

    // State registers; LFSR and toggle free-run independent of mode.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ready_q  <= 1'b0;
            toggle_q <= 1'b1;
            lfsr_q   <= LFSR_SEED;
            beat_q   <= '0;
            pkt_q    <= '0;
        end else begin
            ready_q  <= ready_d;
            toggle_q <= toggle_d;
            lfsr_q   <= lfsr_d;
            beat_q   <= beat_d;
            pkt_q    <= pkt_d;
        end
    end

endmodule

// File: tb/tb_sb_stream_sink.sv
// Self-checking bench for sb_stream_sink: table of run scenarios, hand-written corner
// sequences, and a negedge scoreboard/reference model checking every cycle.
module tb_sb_stream_sink;

    localparam int unsigned DW    = 416;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = 3;
    localparam int unsigned BW    = DW + 33;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic              clk;
    logic              nreset;
    logic [DW-1:0]     data;
    logic [31:0]       dest;
    logic              last;
    logic              valid;
    logic              ready;
    logic              ready_mode_sel;
    logic [1:0]        ready_mode;
    logic [DW-1:0]     out_data;
    logic [31:0]       out_dest;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [LVL_W-1:0]  level;
    logic [31:0]       beat_count;
    logic [31:0]       pkt_count;

    sb_stream_sink #(
        .DW                 (DW),
        .DEPTH              (DEPTH),
        .READY_MODE_DEFAULT (0),
        .LFSR_SEED          (SEED)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .data           (data),
        .dest           (dest),
        .last           (last),
        .valid          (valid),
        .ready          (ready),
        .ready_mode_sel (ready_mode_sel),
        .ready_mode     (ready_mode),
        .out_data       (out_data),
        .out_dest       (out_dest),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .beat_count     (beat_count),
        .pkt_count      (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned src_i = 0;
    int unsigned n_beats = 0;
    int unsigned run_id = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_beat(input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL head_beat: got %h expected %h at %0t", act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int unsigned tag);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < DW / 32; k++) begin
            d[k*32 +: 32] = 32'(tag * 13 + k) ^ 32'hA5A5_0000;
        end
        return d;
    endfunction

    function automatic logic [15:0] lfsr_state(input int unsigned k);
        logic [15:0] s;
        logic        b;
        s = SEED;
        for (int i = 0; i < int'(k); i++) begin
            b = s[0] ^ (s >> 2) ^ (s >> 3) ^ (s >> 5) ? 1'b0 : 1'b0;
            b = ((s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h1) != 16'h0;
            s = (s >> 1) | {b, 15'h0};
        end
        return s;
    endfunction

    function automatic int unsigned lfsr_ones(input int unsigned n);
        int unsigned c;
        logic [15:0] s;
        c = 0;
        for (int unsigned k = 0; k < n; k++) begin
            s = lfsr_state(k);
            c += int'(s[0]);
        end
        return c;
    endfunction

    task automatic drive_src();
        int unsigned tag;
        tag   = run_id * 1000 + src_i;
        valid = (src_i < n_beats);
        data  = mk_data(tag);
        dest  = 32'hD000_0000 | 32'(tag);
        last  = ((src_i % 8) == 7);
    endtask

    // One clock: note acceptance at negedge, then advance the source after the edge.
    task automatic cycle();
        logic acc;
        @(negedge clk);
        acc = valid && ready;
        @(posedge clk);
        #1;
        if (acc) src_i++;
        drive_src();
    endtask

    task automatic start_run(input logic sel, input logic [1:0] mode, input logic ordy,
                             input int unsigned beats);
        nreset    = 1'b0;
        valid     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ready_mode_sel = sel;
        ready_mode     = mode;
        out_ready      = ordy;
        run_id++;
        src_i   = 0;
        n_beats = beats;
        drive_src();
        nreset = 1'b1;
    endtask

    // Reference model + scoreboard, evaluated mid-cycle.
    logic [BW-1:0] sbq [$];
    logic          m_ready;
    logic          m_tog;
    logic [15:0]   m_lfsr;
    logic [31:0]   m_beat;
    logic [31:0]   m_pkt;

    always @(negedge clk) begin
        logic [BW-1:0] e;
        logic [1:0]    md;
        logic          g;
        logic          fb;
        if (!nreset) begin
            sbq.delete();
            m_ready = 1'b0;
            m_tog   = 1'b1;
            m_lfsr  = SEED;
            m_beat  = 0;
            m_pkt   = 0;
        end else begin
            chk("ready", 64'(ready), 64'(m_ready));
            chk("level", 64'(level), 64'(sbq.size()));
            chk("out_valid", 64'(out_valid), 64'(sbq.size() != 0));
            chk("beat_count", 64'(beat_count), 64'(m_beat));
            chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
            if (sbq.size() != 0 && out_ready) begin
                e = sbq.pop_front();
                chk_beat({out_last, out_dest, out_data}, e);
            end
            if (valid && m_ready) begin
                sbq.push_back({last, dest, data});
                m_beat = m_beat + 1;
                m_pkt  = m_pkt + 32'(last);
            end
            md = ready_mode_sel ? ready_mode : 2'd0;
            g  = (md == 2'd1) ? m_lfsr[0] : (md == 2'd2) ? m_tog : 1'b1;
            m_ready = (sbq.size() != DEPTH) && g;
            fb      = ((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h1) != 16'h0;
            m_lfsr  = (m_lfsr >> 1) | {fb, 15'h0};
            m_tog   = !m_tog;
        end
    end

    typedef struct {
        logic        sel;
        logic [1:0]  mode;
        logic        ordy;
        int unsigned beats;
        int unsigned cycles;
        int unsigned exp_beat;
        int unsigned exp_pkt;
        int unsigned exp_level;
        logic        exp_ready;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [15:0] s62, s63;
        int unsigned ones;
        nreset         = 1'b0;
        valid          = 1'b0;
        data           = '0;
        dest           = '0;
        last           = 1'b0;
        out_ready      = 1'b0;
        ready_mode_sel = 1'b1;
        ready_mode     = 2'd0;

        s62  = lfsr_state(62);
        s63  = lfsr_state(63);
        ones = lfsr_ones(63);
        tbl[0] = '{1'b1, 2'd0, 1'b1,    8, 12,  8, 1, 0, 1'b1};
        tbl[1] = '{1'b1, 2'd0, 1'b0,    6, 10,  4, 0, 4, 1'b0};
        tbl[2] = '{1'b1, 2'd2, 1'b1, 1000, 20, 10, 1, 1, 1'b0};
        tbl[3] = '{1'b1, 2'd2, 1'b0, 1000, 20,  4, 0, 4, 1'b0};
        tbl[4] = '{1'b1, 2'd3, 1'b1, 1000, 20, 19, 2, 1, 1'b1};
        tbl[5] = '{1'b0, 2'd2, 1'b1, 1000, 20, 19, 2, 1, 1'b1};
        tbl[6] = '{1'b1, 2'd1, 1'b1, 1000, 64, ones, ones / 8, int'(s62[0]), s63[0]};

        for (int i = 0; i < 7; i++) begin
            start_run(tbl[i].sel, tbl[i].mode, tbl[i].ordy, tbl[i].beats);
            repeat (tbl[i].cycles) cycle();
            chk($sformatf("tbl%0d_beat", i), 64'(beat_count), 64'(tbl[i].exp_beat));
            chk($sformatf("tbl%0d_pkt", i), 64'(pkt_count), 64'(tbl[i].exp_pkt));
            chk($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_ready", i), 64'(ready), 64'(tbl[i].exp_ready));
        end

        // Full FIFO with a simultaneous pop: no pass-through, then refill to 4, then drain.
        start_run(1'b1, 2'd0, 1'b0, 6);
        repeat (10) cycle();
        out_ready = 1'b1;
        chk("full_ready_during_pop", 64'(ready), 64'd0);
        chk("full_level", 64'(level), 64'd4);
        cycle();
        out_ready = 1'b0;
        chk("after_pop_level", 64'(level), 64'd3);
        chk("after_pop_ready", 64'(ready), 64'd1);
        cycle();
        chk("refill_level", 64'(level), 64'd4);
        chk("refill_ready", 64'(ready), 64'd0);
        chk("refill_beat", 64'(beat_count), 64'd5);
        out_ready = 1'b1;
        repeat (10) cycle();
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_beat", 64'(beat_count), 64'd6);

        // Reset asserted mid-stream at level 3.
        start_run(1'b1, 2'd0, 1'b0, 100);
        for (int c = 0; c < 20; c++) begin
            if (level == LVL_W'(3)) break;
            cycle();
        end
        chk("pre_reset_level", 64'(level), 64'd3);
        nreset = 1'b0;
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_beat", 64'(beat_count), 64'd0);
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        run_id++;
        src_i = 0;
        drive_src();
        nreset = 1'b1;
        repeat (3) cycle();
        chk("post_rst_out_valid", 64'(out_valid), 64'd1);
        chk_beat({out_last, out_dest, out_data},
                 {1'b0, 32'hD000_0000 | 32'(run_id * 1000), mk_data(run_id * 1000)});

        // Random out_ready and per-cycle mode changes, then drain.
        start_run(1'b1, 2'd1, 1'b1, 100000);
        for (int c = 0; c < 150; c++) begin
            out_ready      = 1'($urandom_range(0, 1));
            ready_mode_sel = 1'($urandom_range(0, 1));
            ready_mode     = 2'($urandom_range(0, 3));
            cycle();
        end
        n_beats = src_i;
        drive_src();
        ready_mode_sel = 1'b1;
        ready_mode     = 2'd0;
        out_ready      = 1'b1;
        repeat (8) cycle();
        chk("rand_drain_level", 64'(level), 64'd0);
        chk("rand_beat_total", 64'(beat_count), 64'(src_i));

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
